// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int LEN_BYTES  = 4;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Little-endian 8-to-32 byte assembler. The completed word is presented
// combinationally in the cycle its last byte is accepted, so the caller can
// act on it at that same edge.
import imem_loader_pkg::*;

module byte_word_assembler (
  input  logic        clock,
  input  logic        nreset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic [1:0]  cnt,
  output logic        word_valid
);

  logic [23:0] shreg;

  assign word       = {byte_in, shreg};
  assign word_valid = byte_en && (cnt == 2'(WORD_BYTES - 1));

  // Shift accepted bytes in from the top; counter wraps 3 -> 0 on word completion.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (byte_en) begin
      shreg <= {byte_in, shreg[23:8]};
      cnt   <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a length-prefixed little-endian program
// image as a byte stream, writes it into the program RAM and releases the CPU
// reset once the whole image is in place.
// Optional build macro: IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit
// checksum (sum of all data words mod 2^32) that must match for success.
//
// state   | meaning
// S_IDLE  | waiting for load_start after reset
// S_LEN   | collecting the 4-byte word count N
// S_DATA  | collecting N words and writing them to RAM
// S_CHECK | collecting the 4-byte checksum (checksum build only)
// S_DONE  | image loaded, CPU released
// S_ERROR | load aborted, CPU held in reset
import imem_loader_pkg::*;

module imem_loader #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2048,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             load_start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cpu_nreset,
  output logic [AW:0]      word_count
);

  localparam logic [1:0]  LEN_LAST = 2'(LEN_BYTES - 1);
  localparam logic [AW:0] ONE      = {{AW{1'b0}}, 1'b1};

  state_t            state;
  logic [AW:0]       len;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              byte_acc;
  logic              start;
  logic              len_last;
  logic              we;
  logic [31:0]       acc_word;
  logic [1:0]        acc_cnt;
  logic              acc_valid;
  logic [AW:0]       wc_next;
  logic              unused_addr;

  assign byte_acc = rx_valid && rx_ready;
  assign start    = load_start &&
                    ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign len_last = byte_acc && (acc_cnt == LEN_LAST);
  assign we       = nreset && (state == S_DATA) && acc_valid;
  assign wc_next  = word_count + ONE;

  byte_word_assembler u_asm (
    .clock      (clock),
    .nreset     (nreset),
    .clear      (start),
    .byte_en    (byte_acc),
    .byte_in    (rx_data),
    .word       (acc_word),
    .cnt        (acc_cnt),
    .word_valid (acc_valid)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;

  // Running sum of every word written during the current load.
  always_ff @(posedge clock) begin
    if (!nreset)     sum <= '0;
    else if (start)  sum <= '0;
    else if (we)     sum <= sum + acc_word;
  end
`endif

  // Program RAM write port; no reset so contents survive a reset mid-load.
  always_ff @(posedge clock) begin
    if (we) mem[word_count[AW-1:0]] <= acc_word;
  end

  // CPU read port: word addressed, byte offset and upper bits ignored.
  assign rdata       = mem[address[AW+1:2]];
  assign unused_addr = ^{address[WIDTH-1:AW+2], address[1:0]};

  // Load sequencer with registered status outputs.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state      <= S_IDLE;
      rx_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_nreset <= 1'b0;
      word_count <= '0;
      len        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_start) begin
            state      <= S_LEN;
            rx_ready   <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_nreset <= 1'b0;
            word_count <= '0;
          end
        end
        S_LEN: begin
          if (len_last) begin
            if (acc_word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state      <= S_CHECK;
`else
              state      <= S_DONE;
              rx_ready   <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              cpu_nreset <= 1'b1;
`endif
            end else if (acc_word > 32'(DEPTH)) begin
              state    <= S_ERROR;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= S_DATA;
              len   <= acc_word[AW:0];
            end
          end
        end
        S_DATA: begin
          if (acc_valid) begin
            word_count <= wc_next;
            if (wc_next == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state      <= S_CHECK;
`else
              state      <= S_DONE;
              rx_ready   <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              cpu_nreset <= 1'b1;
`endif
            end
          end
        end
        S_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (acc_valid) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if (acc_word == sum) begin
              state      <= S_DONE;
              done       <= 1'b1;
              cpu_nreset <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
            end
          end
`else
          state    <= S_IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
`endif
        end
        default: begin
          state    <= S_IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
